// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Holds the receiver state enum, the bit-timing helper and the frame constants.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Whole system clocks per line bit (floor division).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL is the level both flops take on reset, so the output is quiet
// while the line is unknown.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte valid/ready holding register.
// Optional even parity is compiled in with the macro UART_RX_PARITY_EN;
// without it the frame is pure 8N1 and parity_err is constant 0.
// dbg_state exposes the receiver FSM state for observation.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  logic rxd_s;

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      stop_sample;
  logic                      par_err;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  uart_rx_sync #(
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rxd),
    .q_o     (rxd_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_err = ^{shreg_q, par_bit_q};
`else
  assign par_err = 1'b0;
`endif

  // Next-state logic: start validation, bit-centre sampling and stop check.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d   = par_bit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) state_d = ST_START;
      end
      ST_START: begin
        // Mid-bit recheck rejects short low glitches.
        if (cnt_q == HALF_LAST) begin
          state_d   = rxd_s ? ST_IDLE : ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          // LSB arrives first, so new bits enter at the MSB end.
          shreg_d   = {rxd_s, shreg_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          par_bit_d = rxd_s;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at the stop-bit centre re-arms start detection half a bit early.
        if (cnt_q == BIT_LAST) begin
          stop_sample = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The bit-timing counter restarts on every state entry and rests in IDLE.
    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
    else                                          cnt_d = cnt_q + CNT_W'(1);
  end

  // Holding register.
  // valid/ready: a byte transfers on any cycle where valid && ready are both
  // high at the rising edge; valid only falls through such a transfer, and
  // data is stable while valid is high unless a new byte overruns it.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = stop_sample && !rxd_s;
`ifdef UART_RX_PARITY_EN
    parity_err_d = stop_sample && rxd_s && par_err;
`endif
    if (stop_sample && rxd_s && !par_err) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      if (valid_q && !ready) overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Define UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Edges after the falling edge at which valid is first seen high:
  // 2 sync cycles + half bit + full bits up to the stop centre, then one
  // registered cycle, counting the first sampling edge as edge 1.
  localparam int RISE_LAT = 1 + 2 + HALF + (9 + PAR_BITS) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  // Samples 1 ns after the falling clock edge; inputs driven at that edge are settled.
  always begin
    @(negedge clk);
    #1;
    if (valid && !prev_valid) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    prev_valid = valid;
    if (valid && ready && !reset) got_q.push_back(data);
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: start, 8 data LSB-first, optional even parity (flip to corrupt), stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic par_flip);
    @(negedge clk);
    rxd = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) rxd = 1'b1;
`endif
    rxd = stop_lvl;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit frame_delivers(input logic stop_lvl, input logic par_flip);
`ifdef UART_RX_PARITY_EN
    return stop_lvl && !par_flip;
`else
    return stop_lvl && (par_flip || !par_flip);
`endif
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; rxd = 1'b1; ready = 1'b1;
    idle(3);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_basic;
    int r0, f0, p0;
    r0 = rise_cnt; f0 = fe_cnt; p0 = pe_cnt;
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * CPB);
    total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL basic_rises: got %0d want 1", rise_cnt - r0); end
    total++; if (rise_cyc - fall_cyc !== RISE_LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - fall_cyc, RISE_LAT); end
    total++; if (fe_cnt !== f0 || pe_cnt !== p0) begin bad++; $display("FAIL basic_flags: got fe=%0d pe=%0d want fe=%0d pe=%0d", fe_cnt, pe_cnt, f0, p0); end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", got_q[0]); end
    end
    got_q.delete();
  endtask

  task automatic test_glitch;
    int r0, f0, p0;
    r0 = rise_cnt; f0 = fe_cnt; p0 = pe_cnt;
    @(negedge clk);
    rxd = 1'b0;
    fall_cyc = cyc;
    idle(4);
    rxd = 1'b1;
    idle(6);
    total++; if (dbg_state !== ST_START) begin bad++; $display("FAIL glitch_start: got %0d want %0d", dbg_state, ST_START); end
    idle(1);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL glitch_idle11: got %0d want %0d", dbg_state, ST_IDLE); end
    idle(12 * CPB);
    total++; if (rise_cnt !== r0 || got_q.size() !== 0) begin bad++; $display("FAIL glitch_valid: got rises=%0d want %0d", rise_cnt, r0); end
    total++; if (fe_cnt !== f0 || pe_cnt !== p0) begin bad++; $display("FAIL glitch_flags: got fe=%0d pe=%0d want fe=%0d pe=%0d", fe_cnt, pe_cnt, f0, p0); end
  endtask

  task automatic test_frame_err;
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(3 * CPB);
    total++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_pulse: got %0d want %0d", fe_cnt, f0 + 1); end
    total++; if (rise_cnt !== r0) begin bad++; $display("FAIL ferr_novalid: got rises=%0d want %0d", rise_cnt, r0); end
    send_frame(8'h01, 1'b1, 1'b0);
    idle(2 * CPB);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h01) begin bad++; $display("FAIL ferr_next: got n=%0d want 01", got_q.size()); end
    total++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_next_flag: got %0d want %0d", fe_cnt, f0 + 1); end
    got_q.delete();
  endtask

  task automatic test_overrun;
    @(negedge clk);
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    idle(CPB);
    total++; if (valid !== 1'b1 || data !== 8'h11) begin bad++; $display("FAIL ovr_first: got v=%b d=%h want v=1 d=11", valid, data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", overrun); end
    send_frame(8'h22, 1'b1, 1'b0);
    idle(CPB);
    total++; if (data !== 8'h22 || valid !== 1'b1) begin bad++; $display("FAIL ovr_data: got v=%b d=%h want v=1 d=22", valid, data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    idle(50);
    total++; if (overrun !== 1'b1 || valid !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got ovr=%b v=%b want 1 1", overrun, valid); end
    ready = 1'b1;
    idle(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_drop: got %b want 0", valid); end
    total++; if (data !== 8'h22 || overrun !== 1'b1) begin bad++; $display("FAIL ovr_hold: got d=%h ovr=%b want 22 1", data, overrun); end
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h22) begin bad++; $display("FAIL ovr_accept: got n=%0d want one 22", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_reset_mid;
    int r0;
    ready = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
    idle(CPB);
    rxd = 1'b1;
    idle(4 * CPB + HALF / 2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    r0 = rise_cnt;
    total++; if (data !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL rmid_out: got v=%b d=%h want 0 00", valid, data); end
    total++; if (overrun !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL rmid_flags: got ovr=%b fe=%b pe=%b want 0 0 0", overrun, frame_err, parity_err); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, ST_IDLE); end
    idle(8 * CPB);
    total++; if (rise_cnt !== r0) begin bad++; $display("FAIL rmid_quiet: got rises=%0d want %0d", rise_cnt, r0); end
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(2 * CPB);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A) begin bad++; $display("FAIL rmid_next: got n=%0d want one 5a", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_random;
    int f0, fe_exp;
    logic [7:0] b, e, g;
    logic stop_lvl;
    f0 = fe_cnt; fe_exp = 0;
    ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom_range(0, 255));
      stop_lvl = ($urandom_range(0, 4) != 0);
      send_frame(b, stop_lvl, 1'b0);
      if (frame_delivers(stop_lvl, 1'b0)) exp_q.push_back(b);
      else fe_exp++;
      // A low stop bit needs idle line before the next start edge.
      if (!stop_lvl) idle(CPB + $urandom_range(0, 8));
      else idle($urandom_range(0, 6));
    end
    idle(2 * CPB);
    total++; if (fe_cnt - f0 !== fe_exp) begin bad++; $display("FAIL rand_ferr: got %0d want %0d", fe_cnt - f0, fe_exp); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rand_data: got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int r0, p0;
    ready = 1'b1;
    p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h07) begin bad++; $display("FAIL par_good: got n=%0d want one 07", got_q.size()); end
    total++; if (pe_cnt !== p0) begin bad++; $display("FAIL par_good_flag: got %0d want %0d", pe_cnt, p0); end
    got_q.delete();
    r0 = rise_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    total++; if (pe_cnt !== p0 + 1) begin bad++; $display("FAIL par_bad_flag: got %0d want %0d", pe_cnt, p0 + 1); end
    total++; if (rise_cnt !== r0) begin bad++; $display("FAIL par_bad_valid: got rises=%0d want %0d", rise_cnt, r0); end
  endtask
`else
  task automatic test_no_parity;
    total++; if (pe_cnt !== 0) begin bad++; $display("FAIL nopar_flag: got %0d want 0", pe_cnt); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
